// File: rtl/uart_frame_streamer_pkg.sv
// Shared opcodes, header byte, FSM state encoding and mode type for the frame streamer.
package uart_frame_streamer_pkg;

  localparam logic [7:0] CMD_F        = 8'h46;
  localparam logic [7:0] CMD_W        = 8'h57;
  localparam logic [7:0] CMD_D        = 8'h44;
  localparam logic [7:0] CMD_X        = 8'h58;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HDR0      = 4'd1,
    ST_HDR1      = 4'd2,
    ST_WAIT_LINE = 4'd3,
    ST_RD        = 4'd4,
    ST_LATCH     = 4'd5,
    ST_SEND_HI   = 4'd6,
    ST_SEND_LO   = 4'd7,
    ST_NEXT      = 4'd8,
    ST_DRAIN     = 4'd9,
    ST_ABORT     = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_F    = 2'd1,
    MODE_W    = 2'd2,
    MODE_D    = 2'd3
  } mode_t;

  // Second header byte echoes the command that started the frame.
  function automatic logic [7:0] mode_cmd(input mode_t m);
    case (m)
      MODE_F:  return CMD_F;
      MODE_W:  return CMD_W;
      MODE_D:  return CMD_D;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_streamer_if.sv
// UART and line_buffer handshake bundle; master is the streamer, slave is the surrounding logic.
interface uart_frame_streamer_if #(
  parameter int H     = 752,
  parameter int V     = 480,
  parameter int PIX_W = 10
);
  localparam int AW = $clog2(H);
  localparam int LW = $clog2(V);

  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             tx_idle;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             line_ready;
  logic [PIX_W-1:0] pix_data;
  logic [LW-1:0]    req_line;
  logic [AW-1:0]    rd_addr;
  logic             rel;
  logic             busy;
  logic             frame_done;

  modport master (
    input  rx_data, rx_ready, tx_idle, line_ready, pix_data,
    output tx_data, tx_start, req_line, rd_addr, rel, busy, frame_done
  );

  modport slave (
    output rx_data, rx_ready, tx_idle, line_ready, pix_data,
    input  tx_data, tx_start, req_line, rd_addr, rel, busy, frame_done
  );
endinterface

// File: rtl/uart_frame_streamer_decoder.sv
// RX_READY rising-edge detector and opcode decoder producing registered one-cycle command strobes.
module stream_cmd_decoder
  import uart_frame_streamer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_ready,
  output logic       o_start_f,
  output logic       o_start_w,
  output logic       o_start_d,
  output logic       o_abort
);
  logic r_rx_ready_d;
  logic r_start_f;
  logic r_start_w;
  logic r_start_d;
  logic r_abort;
  logic w_edge;

  assign w_edge = i_rx_ready & ~r_rx_ready_d;

  // Edge register tracks RX_READY even in reset so a level held through reset is not a command.
  always_ff @(posedge i_clk) begin
    r_rx_ready_d <= i_rx_ready;
    if (i_rst) begin
      r_start_f <= 1'b0;
      r_start_w <= 1'b0;
      r_start_d <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_start_f <= w_edge && (i_rx_data == CMD_F);
      r_start_w <= w_edge && (i_rx_data == CMD_W);
      r_start_d <= w_edge && (i_rx_data == CMD_D);
      r_abort   <= w_edge && (i_rx_data == CMD_X);
    end
  end

  assign o_start_f = r_start_f;
  assign o_start_w = r_start_w;
  assign o_start_d = r_start_d;
  assign o_abort   = r_abort;
endmodule

// File: rtl/uart_frame_streamer.sv
// Command-driven frame dump controller: header, then pixels in F/W/D mode, with abort.
module uart_frame_streamer
  import uart_frame_streamer_pkg::*;
#(
  parameter int         H     = 752,
  parameter int         V     = 480,
  parameter int         PIX_W = 10,
  parameter int         DECIM = 2,
  parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
  input logic                   i_clk,
  input logic                   i_rst,
  uart_frame_streamer_if.master io_bus
);
  localparam int AW = $clog2(H);
  localparam int LW = $clog2(V);

  state_t           r_state, w_state_nx;
  mode_t            r_mode, w_mode_nx;
  logic [7:0]       r_tx_data, w_tx_data_nx;
  logic             r_tx_start, w_tx_start_nx;
  logic [LW-1:0]    r_req_line, w_req_line_nx;
  logic [AW-1:0]    r_rd_addr, w_rd_addr_nx;
  logic             r_rel, w_rel_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic [PIX_W-1:0] r_hold, w_hold_nx;

  logic       w_start_f, w_start_w, w_start_d, w_abort;
  logic       w_tx_ok;
  logic [AW:0] w_step_a, w_addr_sum;
  logic [LW:0] w_step_l, w_line_sum;
  logic [15:0] w_hold16;
  logic [7:0]  w_pix8;

  stream_cmd_decoder u_dec (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_data  (io_bus.rx_data),
    .i_rx_ready (io_bus.rx_ready),
    .o_start_f  (w_start_f),
    .o_start_w  (w_start_w),
    .o_start_d  (w_start_d),
    .o_abort    (w_abort)
  );

  // The previous-cycle strobe guard covers the cycle before uart_send drops TX_IDLE.
  assign w_tx_ok    = io_bus.tx_idle && !r_tx_start;
  assign w_step_a   = (r_mode == MODE_D) ? (AW+1)'(DECIM) : (AW+1)'(1);
  assign w_step_l   = (r_mode == MODE_D) ? (LW+1)'(DECIM) : (LW+1)'(1);
  assign w_addr_sum = {1'b0, r_rd_addr} + w_step_a;
  assign w_line_sum = {1'b0, r_req_line} + w_step_l;
  assign w_hold16   = 16'(r_hold);
  assign w_pix8     = r_hold[PIX_W-1 -: 8];

  // Next-state and next-output logic; abort outranks every transition out of a busy state.
  always_comb begin
    w_state_nx    = r_state;
    w_mode_nx     = r_mode;
    w_tx_data_nx  = r_tx_data;
    w_tx_start_nx = 1'b0;
    w_req_line_nx = r_req_line;
    w_rd_addr_nx  = r_rd_addr;
    w_rel_nx      = 1'b0;
    w_busy_nx     = r_busy;
    w_done_nx     = 1'b0;
    w_hold_nx     = r_hold;
    if (w_abort && (r_state != ST_IDLE)) begin
      w_state_nx = ST_ABORT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_f || w_start_w || w_start_d) begin
            w_mode_nx     = w_start_f ? MODE_F : (w_start_w ? MODE_W : MODE_D);
            w_busy_nx     = 1'b1;
            w_req_line_nx = '0;
            w_rd_addr_nx  = '0;
            w_rel_nx      = 1'b1;
            w_state_nx    = ST_HDR0;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        ST_HDR0: begin
          if (w_tx_ok) begin
            w_tx_start_nx = 1'b1;
            w_tx_data_nx  = SYNC;
            w_state_nx    = ST_HDR1;
          end else begin
            w_state_nx = ST_HDR0;
          end
        end
        ST_HDR1: begin
          if (w_tx_ok) begin
            w_tx_start_nx = 1'b1;
            w_tx_data_nx  = mode_cmd(r_mode);
            w_state_nx    = ST_WAIT_LINE;
          end else begin
            w_state_nx = ST_HDR1;
          end
        end
        ST_WAIT_LINE: begin
          if (io_bus.line_ready) begin
            w_state_nx = ST_RD;
          end else begin
            w_state_nx = ST_WAIT_LINE;
          end
        end
        ST_RD: w_state_nx = ST_LATCH;
        ST_LATCH: begin
          w_hold_nx  = io_bus.pix_data;
          w_state_nx = ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (w_tx_ok) begin
            w_tx_start_nx = 1'b1;
            w_tx_data_nx  = (r_mode == MODE_W) ? w_hold16[15:8] : w_pix8;
            w_state_nx    = (r_mode == MODE_W) ? ST_SEND_LO : ST_NEXT;
          end else begin
            w_state_nx = ST_SEND_HI;
          end
        end
        ST_SEND_LO: begin
          if (w_tx_ok) begin
            w_tx_start_nx = 1'b1;
            w_tx_data_nx  = w_hold16[7:0];
            w_state_nx    = ST_NEXT;
          end else begin
            w_state_nx = ST_SEND_LO;
          end
        end
        ST_NEXT: begin
          if (w_addr_sum < (AW+1)'(H)) begin
            w_rd_addr_nx = w_addr_sum[AW-1:0];
            w_state_nx   = ST_RD;
          end else if (w_line_sum < (LW+1)'(V)) begin
            w_req_line_nx = w_line_sum[LW-1:0];
            w_rd_addr_nx  = '0;
            w_rel_nx      = 1'b1;
            w_state_nx    = ST_WAIT_LINE;
          end else begin
            w_state_nx = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_tx_ok) begin
            w_done_nx     = 1'b1;
            w_busy_nx     = 1'b0;
            w_req_line_nx = '0;
            w_rd_addr_nx  = '0;
            w_state_nx    = ST_IDLE;
          end else begin
            w_state_nx = ST_DRAIN;
          end
        end
        ST_ABORT: begin
          if (w_tx_ok) begin
            w_rel_nx      = 1'b1;
            w_busy_nx     = 1'b0;
            w_req_line_nx = '0;
            w_rd_addr_nx  = '0;
            w_state_nx    = ST_IDLE;
          end else begin
            w_state_nx = ST_ABORT;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // State and registered-output update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_NONE;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_req_line <= '0;
      r_rd_addr  <= '0;
      r_rel      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_mode     <= w_mode_nx;
      r_tx_data  <= w_tx_data_nx;
      r_tx_start <= w_tx_start_nx;
      r_req_line <= w_req_line_nx;
      r_rd_addr  <= w_rd_addr_nx;
      r_rel      <= w_rel_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_hold     <= w_hold_nx;
    end
  end

  assign io_bus.tx_data    = r_tx_data;
  assign io_bus.tx_start   = r_tx_start;
  assign io_bus.req_line   = r_req_line;
  assign io_bus.rd_addr    = r_rd_addr;
  assign io_bus.rel        = r_rel;
  assign io_bus.busy       = r_busy;
  assign io_bus.frame_done = r_done;
endmodule
